// File: rtl/leg_shift_pkg.sv
// Shared types and constants for the barrel-shifter control front end:
// shift types, carry-source selects, FSM states and the registered control bundle.
package leg_shift_pkg;

  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shtype_e;

  typedef enum logic [2:0] {
    CSEL_C_IN  = 3'd0,
    CSEL_ROT0  = 3'd1,
    CSEL_ROT31 = 3'd2,
    CSEL_A0    = 3'd3,
    CSEL_A31   = 3'd4,
    CSEL_ZERO  = 3'd5
  } csel_e;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT_RS = 2'd1,
    S_OUT     = 2'd2
  } state_e;

  localparam logic [4:0] SHCTL5_ID  = 5'b00001;
  localparam logic [4:0] SHCTL5_RRX = 5'b00010;
  localparam logic [7:0] SHCTL8_ID  = 8'b00000001;

  typedef struct packed {
    logic [4:0] shamt;
    logic [4:0] shctl_5;
    logic [7:0] shctl_8;
    logic       longshift;
    logic       left;
    logic       shift;
    logic       arith;
    logic       rrx_sel;
    csel_e      csel;
  } shctl_t;

  localparam shctl_t SHCTL_RESET = '{
    shamt:     5'd0,
    shctl_5:   SHCTL5_ID,
    shctl_8:   SHCTL8_ID,
    longshift: 1'b0,
    left:      1'b0,
    shift:     1'b0,
    arith:     1'b0,
    rrx_sel:   1'b0,
    csel:      CSEL_C_IN
  };

  function automatic logic [4:0] onehot5(input logic [2:0] idx);
    return 5'b00001 << idx;
  endfunction

  function automatic logic [7:0] onehot8(input logic [2:0] idx);
    return 8'b00000001 << idx;
  endfunction

endpackage

// File: rtl/shift_amt_decode.sv
// Combinational decode of an ARM shifter operand (type, form, amount) into the
// shifter control bundle: ROR selects, mask mode and carry-out source.
module shift_amt_decode
  import leg_shift_pkg::*;
#(
  parameter int RS_W = 8
) (
  input  logic [1:0]      shtype,
  input  logic            imm_shift,
  input  logic [4:0]      shamt_imm,
  input  logic [RS_W-1:0] rs_val,
  output shctl_t          ctl
);

  localparam logic [RS_W-1:0] AMT_32 = RS_W'(32);

  shtype_e         st;
  logic [RS_W-1:0] amt;
  logic            zero_amt;
  logic            big;
  logic            rrx;
  logic            no_shift;
  logic [5:0]      n;
  logic [4:0]      n_inv;

  assign st       = shtype_e'(shtype);
  assign amt      = imm_shift ? RS_W'(shamt_imm) : rs_val;
  assign zero_amt = (amt == '0);
  assign big      = (amt > AMT_32);
  assign rrx      = imm_shift && zero_amt && (st == SH_ROR);
  assign no_shift = zero_amt && (!imm_shift || st == SH_LSL);
  // Immediate LSR/ASR #0 encodes a shift by 32; register amounts saturate at 32.
  assign n        = (imm_shift && zero_amt) ? 6'd32 :
                    (amt >= AMT_32)         ? 6'd32 : amt[5:0];
  assign n_inv    = ~n[4:0];

  always_comb begin
    // NOTE: every field gets its default before the case split, so no path
    // through this block can leave a field unassigned and infer a latch.
    ctl = SHCTL_RESET;
    if (no_shift) begin
      ctl = SHCTL_RESET;
    end else if (rrx) begin
      ctl.shctl_5 = SHCTL5_RRX;
      ctl.rrx_sel = 1'b1;
      ctl.csel    = CSEL_A0;
    end else begin
      unique case (st)
        SH_LSL: begin
          // Left shift rotates right by 32-n; the low stage takes 1..4 so the
          // high stage never needs a carry from the +1.
          ctl.left    = 1'b1;
          ctl.shift   = 1'b1;
          ctl.shamt   = n[4:0];
          ctl.shctl_5 = onehot5({1'b0, n_inv[1:0]} + 3'd1);
          ctl.shctl_8 = onehot8(n_inv[4:2]);
          if (n == 6'd32) begin
            ctl.longshift = 1'b1;
            ctl.csel      = big ? CSEL_ZERO : CSEL_A0;
          end else begin
            ctl.csel = CSEL_ROT0;
          end
        end
        SH_LSR, SH_ASR: begin
          ctl.shift   = 1'b1;
          ctl.arith   = (st == SH_ASR);
          ctl.shamt   = n[4:0];
          ctl.shctl_5 = onehot5({1'b0, n[1:0]});
          ctl.shctl_8 = onehot8(n[4:2]);
          if (n == 6'd32) begin
            ctl.longshift = 1'b1;
            ctl.csel      = (st == SH_ASR || !big) ? CSEL_A31 : CSEL_ZERO;
          end else begin
            ctl.csel = CSEL_ROT31;
          end
        end
        SH_ROR: begin
          if (amt[4:0] == 5'd0) begin
            ctl.csel = CSEL_A31;
          end else begin
            ctl.shctl_5 = onehot5({1'b0, amt[1:0]});
            ctl.shctl_8 = onehot8(amt[4:2]);
            ctl.csel    = CSEL_ROT31;
          end
        end
        default: ctl = SHCTL_RESET;
      endcase
    end
  end

endmodule

// File: rtl/shift_ctl_gen.sv
// Execute-stage barrel shifter control generator: accepts a shifter operand,
// waits for Rs when register-specified, and holds registered controls until consumed.
module shift_ctl_gen
  import leg_shift_pkg::*;
#(
  parameter int RS_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      shtype,
  input  logic            imm_shift,
  input  logic [4:0]      shamt_imm,
  input  logic            rs_valid,
  input  logic [RS_W-1:0] rs_val,
  input  logic            flush,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [4:0]      shamt,
  output logic [4:0]      shctl_5,
  output logic [7:0]      shctl_8,
  output logic            longshift,
  output logic            left,
  output logic            shift,
  output logic            arith,
  output logic            rrx_sel,
  output logic [2:0]      csel
);

  state_e     state;
  logic [1:0] held_type;
  shctl_t     ctl_q;
  shctl_t     dec;
  logic [1:0] dec_type;
  logic       dec_imm;
  logic       accept_slot;

  // While waiting for Rs the operand type comes from the held copy, not the bus.
  assign dec_type    = (state == S_WAIT_RS) ? held_type : shtype;
  assign dec_imm     = (state == S_WAIT_RS) ? 1'b0 : imm_shift;
  assign accept_slot = (state == S_IDLE) || (state == S_OUT && out_ready);
  assign in_ready    = accept_slot;

  shift_amt_decode #(.RS_W(RS_W)) u_decode (
    .shtype    (dec_type),
    .imm_shift (dec_imm),
    .shamt_imm (shamt_imm),
    .rs_val    (rs_val),
    .ctl       (dec)
  );

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
      held_type <= 2'b00;
      ctl_q     <= SHCTL_RESET;
    end else if (flush) begin
      state     <= S_IDLE;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE, S_OUT: begin
          if (accept_slot) begin
            if (in_valid && (imm_shift || rs_valid)) begin
              state     <= S_OUT;
              out_valid <= 1'b1;
              ctl_q     <= dec;
            end else if (in_valid) begin
              state     <= S_WAIT_RS;
              out_valid <= 1'b0;
              held_type <= shtype;
            end else begin
              state     <= S_IDLE;
              out_valid <= 1'b0;
            end
          end
        end
        S_WAIT_RS: begin
          if (rs_valid) begin
            state     <= S_OUT;
            out_valid <= 1'b1;
            ctl_q     <= dec;
          end
        end
        default: begin
          state     <= S_IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign shamt     = ctl_q.shamt;
  assign shctl_5   = ctl_q.shctl_5;
  assign shctl_8   = ctl_q.shctl_8;
  assign longshift = ctl_q.longshift;
  assign left      = ctl_q.left;
  assign shift     = ctl_q.shift;
  assign arith     = ctl_q.arith;
  assign rrx_sel   = ctl_q.rrx_sel;
  assign csel      = ctl_q.csel;

endmodule
